countdown_timer_main: RTL

//   Countdown timer, the down-counting counterpart of the stopwatch. User presets
//   MM:SS with keys, starts/pauses with key2; timer counts centiseconds down to
//   00:00.00, then raises an alarm. time_display feeds the show_time sevenseg decoder;
//   led drives the 10 board LEDs.

---
 rtl/countdown_timer_main.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/countdown_timer_main.sv
// Centisecond countdown timer: MM:SS preset via keys, start/pause/resume,
// alarm on expiry with auto-return to IDLE after ALARM_CS ticks.
module countdown_timer_main #(
    parameter int TICK_DIV = 1,
    parameter int ALARM_CS = 1000
) (
    input  logic        clk,
    input  logic        key3,
    input  logic        key2,
    input  logic        key1,
    input  logic        key0,
    output logic [18:0] time_display,
    output logic [1:0]  state,
    output logic        alarm,
    output logic [9:0]  led
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int AW = (ALARM_CS > 1) ? $clog2(ALARM_CS) : 1;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_RUNNING = 2'd1,
        S_PAUSED  = 2'd2,
        S_EXPIRED = 2'd3
    } state_t;

    logic [2:0]    sync1_q, sync1_d;
    logic [2:0]    sync2_q, sync2_d;
    logic [2:0]    prev_q, prev_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [5:0]    preset_min_q, preset_min_d;
    logic [5:0]    preset_sec_q, preset_sec_d;
    logic [18:0]   remaining_q, remaining_d;
    logic [AW-1:0] alarm_cnt_q, alarm_cnt_d;
    state_t        state_q, state_d;
    logic [18:0]   time_display_q, time_display_d;
    logic          alarm_q, alarm_d;
    logic [9:0]    led_q, led_d;

    logic [2:0]    press;
    logic          p2, p1, p0;
    logic          tick;
    logic [18:0]   preset_cs_q, preset_cs_d;
    logic [3:0]    digit;
    logic          blink_off;

    function automatic logic [18:0] to_cs(input logic [5:0] mm, input logic [5:0] ss);
        return 19'(mm) * 19'd6000 + 19'(ss) * 19'd100;
    endfunction

    // Press = falling edge of the synchronized key; held keys do not repeat.
    assign press = prev_q & ~sync2_q;
    assign p2    = press[2];
    assign p1    = press[1] & ~press[2];
    assign p0    = press[0] & ~press[1] & ~press[2];

    assign tick        = (presc_q == PW'(TICK_DIV - 1));
    assign preset_cs_q = to_cs(preset_min_q, preset_sec_q);

    always_comb begin
        sync1_d      = {key2, key1, key0};
        sync2_d      = sync1_q;
        prev_d       = sync2_q;
        presc_d      = tick ? '0 : presc_q + PW'(1);
        preset_min_d = preset_min_q;
        preset_sec_d = preset_sec_q;
        remaining_d  = remaining_q;
        alarm_cnt_d  = alarm_cnt_q;
        state_d      = state_q;

        case (state_q)
            S_IDLE: begin
                if (p2) begin
                    if (preset_cs_q != 19'd0) begin
                        state_d     = S_RUNNING;
                        remaining_d = preset_cs_q;
                    end
                end else if (p1) begin
                    preset_min_d = (preset_min_q == 6'd59) ? 6'd0 : preset_min_q + 6'd1;
                end else if (p0) begin
                    preset_sec_d = (preset_sec_q == 6'd59) ? 6'd0 : preset_sec_q + 6'd1;
                end
            end
            S_RUNNING: begin
                // A pause wins over a tick landing on the same edge.
                if (p2) begin
                    state_d = S_PAUSED;
                end else if (tick) begin
                    if (remaining_q <= 19'd1) begin
                        remaining_d = 19'd0;
                        alarm_cnt_d = '0;
                        state_d     = S_EXPIRED;
                    end else begin
                        remaining_d = remaining_q - 19'd1;
                    end
                end
            end
            S_PAUSED: begin
                if (p2) state_d = S_RUNNING;
            end
            S_EXPIRED: begin
                remaining_d = 19'd0;
                if (p2) begin
                    state_d = S_IDLE;
                end else if (tick) begin
                    if (alarm_cnt_q == AW'(ALARM_CS - 1)) state_d = S_IDLE;
                    else alarm_cnt_d = alarm_cnt_q + AW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs are registered from next-state values so they line up with state.
    always_comb begin
        preset_cs_d    = to_cs(preset_min_d, preset_sec_d);
        digit          = 4'((remaining_d / 19'd100) % 19'd10);
        blink_off      = 1'((32'(alarm_cnt_d) / 32'd50) % 32'd2);
        time_display_d = (state_d == S_IDLE) ? preset_cs_d : remaining_d;
        alarm_d        = (state_d == S_EXPIRED);
        led_d          = 10'd0;
        case (state_d)
            S_RUNNING, S_PAUSED: led_d = 10'h200 >> digit;
            S_EXPIRED:           led_d = blink_off ? 10'h000 : 10'h3FF;
            default:             led_d = 10'd0;
        endcase
    end

    always_ff @(posedge clk or negedge key3) begin
        if (!key3) begin
            sync1_q        <= 3'b111;
            sync2_q        <= 3'b111;
            prev_q         <= 3'b111;
            presc_q        <= '0;
            preset_min_q   <= 6'd0;
            preset_sec_q   <= 6'd0;
            remaining_q    <= 19'd0;
            alarm_cnt_q    <= '0;
            state_q        <= S_IDLE;
            time_display_q <= 19'd0;
            alarm_q        <= 1'b0;
            led_q          <= 10'd0;
        end else begin
            sync1_q        <= sync1_d;
            sync2_q        <= sync2_d;
            prev_q         <= prev_d;
            presc_q        <= presc_d;
            preset_min_q   <= preset_min_d;
            preset_sec_q   <= preset_sec_d;
            remaining_q    <= remaining_d;
            alarm_cnt_q    <= alarm_cnt_d;
            state_q        <= state_d;
            time_display_q <= time_display_d;
            alarm_q        <= alarm_d;
            led_q          <= led_d;
        end
    end

    assign time_display = time_display_q;
    assign state        = state_q;
    assign alarm        = alarm_q;
    assign led          = led_q;

endmodule
